rf_wb_ctrl: RTL and testbench

- Write-side controller for the CPU integer register file.
- Accepts writeback requests from EXU and LSU over valid/ready handshakes and arbitrates them round-robin onto the single register-file write port.
- Keeps a per-register busy scoreboard that the IDU sets at issue, and answers two combinational hazard queries per cycle.
- Sits between EXU/LSU and the register-file write port (we/waddr/wdata).

---
 rtl/rf_wb_ctrl_pkg.sv | 15 +
 rtl/rf_wb_ctrl_arb.sv | 31 +++
 rtl/rf_wb_ctrl.sv | 102 ++++++++++
 tb/tb_rf_wb_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_ctrl_pkg.sv
// Shared definitions for the integer register-file write-side controller.
package rf_wb_ctrl_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 5;
  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ZERO_REG       = 0;
  localparam int unsigned NUM_REGS       = 2 ** ADDR_WIDTH_DEF;

  // Writeback source; also the encoding of the arbiter's last-grant flop.
  typedef enum logic {
    SRC_EXU = 1'b0,
    SRC_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/rf_wb_ctrl_arb.sv
// Two-request round-robin arbiter (req[0]=EXU, req[1]=LSU) with a last-grant flop.
module wb_rr_arb2
  import rf_wb_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output wb_src_e    last
);

  // On a tie the source that did not win the previous tie is granted.
  always_comb begin
    gnt = '0;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == SRC_EXU) ? 2'b10 : 2'b01;
      default: gnt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last <= SRC_EXU;
    end else if (req == 2'b11) begin
      last <= gnt[1] ? SRC_LSU : SRC_EXU;
    end
  end

endmodule

// File: rtl/rf_wb_ctrl.sv
// Register-file write-side controller: EXU/LSU writeback arbitration,
// registered write port and per-register busy scoreboard.
module rf_wb_ctrl
  import rf_wb_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rsv_valid,
  input  logic [ADDR_WIDTH-1:0]    rsv_addr,
  output logic                     rsv_ready,
  input  logic                     exu_valid,
  input  logic [ADDR_WIDTH-1:0]    exu_addr,
  input  logic [DATA_WIDTH-1:0]    exu_data,
  output logic                     exu_ready,
  input  logic                     lsu_valid,
  input  logic [ADDR_WIDTH-1:0]    lsu_addr,
  input  logic [DATA_WIDTH-1:0]    lsu_data,
  output logic                     lsu_ready,
  output logic                     rf_we,
  output logic [ADDR_WIDTH-1:0]    rf_waddr,
  output logic [DATA_WIDTH-1:0]    rf_wdata,
  input  logic [ADDR_WIDTH-1:0]    chk_addr1,
  input  logic [ADDR_WIDTH-1:0]    chk_addr2,
  output logic                     chk_busy1,
  output logic                     chk_busy2,
  output logic [2**ADDR_WIDTH-1:0] busy_vec,
  output logic                     wb_err
);

  localparam int unsigned NREGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

  logic [NREGS-1:0]      busy_q;
  logic [NREGS-1:0]      busy_next;
  logic [1:0]            gnt;
  wb_src_e               last_gnt;
  logic                  grant;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_nonzero;
  logic                  rsv_fire;

  wb_rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  ({lsu_valid, exu_valid}),
    .gnt  (gnt),
    .last (last_gnt)
  );

  assign exu_ready   = gnt[0];
  assign lsu_ready   = gnt[1];
  assign grant       = |gnt;
  assign sel_addr    = gnt[1] ? lsu_addr : exu_addr;
  assign sel_data    = gnt[1] ? lsu_data : exu_data;
  assign sel_nonzero = (sel_addr != ZERO_ADDR);

  assign rsv_ready = !busy_q[rsv_addr] || (rsv_addr == ZERO_ADDR);
  assign rsv_fire  = rsv_valid && rsv_ready && (rsv_addr != ZERO_ADDR);

  assign chk_busy1 = busy_q[chk_addr1];
  assign chk_busy2 = busy_q[chk_addr2];
  assign busy_vec  = busy_q;

  // Clear from the committing write first, so a same-index reservation wins.
  always_comb begin
    busy_next = busy_q;
    if (rf_we) busy_next[rf_waddr] = 1'b0;
    if (rsv_fire) busy_next[rsv_addr] = 1'b1;
    busy_next[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q   <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      wb_err   <= 1'b0;
    end else begin
      busy_q <= busy_next;
      rf_we  <= grant && sel_nonzero;
      if (grant) begin
        rf_waddr <= sel_addr;
        rf_wdata <= sel_data;
      end
      if (grant && sel_nonzero && !busy_q[sel_addr]) begin
        wb_err <= 1'b1;
      end
    end
  end

  // A tie must leave the last-grant flop naming the source just granted.
  tie_records_winner: assert property (
    @(posedge clk) disable iff (!rst)
      (exu_valid && lsu_valid) |=> (last_gnt == ($past(lsu_ready) ? SRC_LSU : SRC_EXU))
  );

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Directed bench for rf_wb_ctrl: expected writes queued by the driver,
// popped and compared by a monitor whenever the register-file port writes.
module tb_rf_wb_ctrl;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst;
  logic          rsv_valid;
  logic [AW-1:0] rsv_addr;
  logic          rsv_ready;
  logic          exu_valid;
  logic [AW-1:0] exu_addr;
  logic [DW-1:0] exu_data;
  logic          exu_ready;
  logic          lsu_valid;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_data;
  logic          lsu_ready;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [AW-1:0] chk_addr1;
  logic [AW-1:0] chk_addr2;
  logic          chk_busy1;
  logic          chk_busy2;
  logic [31:0]   busy_vec;
  logic          wb_err;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_t;

  wb_t exp_q[$];
  int  vec_cnt;
  int  fail_cnt;

  rf_wb_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .rsv_ready (rsv_ready),
    .exu_valid (exu_valid),
    .exu_addr  (exu_addr),
    .exu_data  (exu_data),
    .exu_ready (exu_ready),
    .lsu_valid (lsu_valid),
    .lsu_addr  (lsu_addr),
    .lsu_data  (lsu_data),
    .lsu_ready (lsu_ready),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .chk_addr1 (chk_addr1),
    .chk_addr2 (chk_addr2),
    .chk_busy1 (chk_busy1),
    .chk_busy2 (chk_busy2),
    .busy_vec  (busy_vec),
    .wb_err    (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Monitor: every committed register-file write must match the queue head.
  always @(negedge clk) begin
    if (rst === 1'b1 && rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        vec_cnt++;
        fail_cnt++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write",
                 rf_waddr, rf_wdata);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        chk("wb_addr", 64'(rf_waddr), 64'(e.addr));
        chk("wb_data", 64'(rf_wdata), 64'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_cnt   = 0;
    fail_cnt  = 0;
    rst       = 1'b0;
    rsv_valid = 1'b0;
    rsv_addr  = '0;
    exu_valid = 1'b0;
    exu_addr  = '0;
    exu_data  = '0;
    lsu_valid = 1'b0;
    lsu_addr  = '0;
    lsu_data  = '0;
    chk_addr1 = '0;
    chk_addr2 = '0;
    do_reset();

    chk("rst_busy_vec", 64'(busy_vec), 64'h0);
    chk("rst_rf_we", 64'(rf_we), 64'h0);
    chk("rst_wb_err", 64'(wb_err), 64'h0);

    // Asynchronous reset mid-cycle with a write in flight.
    rsv_valid = 1'b1; rsv_addr = 5'd3;
    tick();
    rsv_valid = 1'b0;
    exu_valid = 1'b1; exu_addr = 5'd3; exu_data = 32'h0000_CAFE;
    chk("pre_rst_busy", 64'(busy_vec), 64'h8);
    tick();
    exu_valid = 1'b0;
    chk("pre_rst_we", 64'(rf_we), 64'h1);
    #2 rst = 1'b0;
    #1;
    chk("async_busy_vec", 64'(busy_vec), 64'h0);
    chk("async_rf_we", 64'(rf_we), 64'h0);
    chk("async_wb_err", 64'(wb_err), 64'h0);
    chk("async_rf_waddr", 64'(rf_waddr), 64'h0);
    tick();
    rst = 1'b1;

    // Reserve x5, then EXU writeback.
    rsv_valid = 1'b1; rsv_addr = 5'd5;
    #1 chk("rsv5_ready", 64'(rsv_ready), 64'h1);
    tick();
    rsv_valid = 1'b0;
    chk("rsv5_busy_vec", 64'(busy_vec), 64'h20);
    tick();
    exu_valid = 1'b1; exu_addr = 5'd5; exu_data = 32'hDEAD_BEEF;
    push(5'd5, 32'hDEAD_BEEF);
    #1;
    chk("x5_exu_ready", 64'(exu_ready), 64'h1);
    chk("x5_lsu_ready", 64'(lsu_ready), 64'h0);
    tick();
    exu_valid = 1'b0;
    chk_addr1 = 5'd5;
    #1;
    chk("x5_rf_waddr", 64'(rf_waddr), 64'h5);
    chk("x5_busy_during_we", 64'(chk_busy1), 64'h1);
    tick();
    chk("x5_busy_after", 64'(chk_busy1), 64'h0);
    chk("x5_busy_vec_clear", 64'(busy_vec), 64'h0);

    // WAW stall on x7 until the LSU write commits.
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    #1 chk("rsv7_ready", 64'(rsv_ready), 64'h1);
    tick();
    lsu_valid = 1'b1; lsu_addr = 5'd7; lsu_data = 32'h0777_0777;
    chk_addr2 = 5'd7;
    push(5'd7, 32'h0777_0777);
    #1;
    chk("waw_rsv_stall", 64'(rsv_ready), 64'h0);
    chk("waw_lsu_ready", 64'(lsu_ready), 64'h1);
    chk("waw_exu_ready", 64'(exu_ready), 64'h0);
    chk("waw_busy2", 64'(chk_busy2), 64'h1);
    tick();
    lsu_valid = 1'b0;
    #1;
    chk("waw_we", 64'(rf_we), 64'h1);
    chk("waw_stall_during_we", 64'(rsv_ready), 64'h0);
    tick();
    chk("waw_we_done", 64'(rf_we), 64'h0);
    chk("waw_rsv_release", 64'(rsv_ready), 64'h1);
    chk("waw_busy2_clear", 64'(chk_busy2), 64'h0);
    tick();
    rsv_valid = 1'b0;
    chk("waw_rereserved", 64'(busy_vec), 64'h80);
    chk("waw_wb_err", 64'(wb_err), 64'h0);

    // x0: reservation accepted but never marks busy; writeback is swallowed.
    rsv_valid = 1'b1; rsv_addr = 5'd0;
    #1 chk("x0_rsv_ready", 64'(rsv_ready), 64'h1);
    tick();
    rsv_valid = 1'b0;
    chk("x0_busy_vec", 64'(busy_vec), 64'h80);
    exu_valid = 1'b1; exu_addr = 5'd0; exu_data = 32'h0000_1234;
    #1 chk("x0_exu_ready", 64'(exu_ready), 64'h1);
    tick();
    exu_valid = 1'b0;
    chk("x0_rf_we", 64'(rf_we), 64'h0);
    chk("x0_wb_err", 64'(wb_err), 64'h0);

    // Round-robin under sustained contention.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exu_valid = 1'b1; exu_addr = 5'd1; exu_data = 32'h100 + 32'(i);
      lsu_valid = 1'b1; lsu_addr = 5'd2; lsu_data = 32'h200 + 32'(i);
      if (i % 2 == 0) push(5'd2, 32'h200 + 32'(i));
      else            push(5'd1, 32'h100 + 32'(i));
      #1;
      chk("rr_exu_ready", 64'(exu_ready), (i % 2 == 0) ? 64'h0 : 64'h1);
      chk("rr_lsu_ready", 64'(lsu_ready), (i % 2 == 0) ? 64'h1 : 64'h0);
      chk("rr_one_hot", 64'(exu_ready & lsu_ready), 64'h0);
      tick();
    end
    // A lone request must not move the last-grant pointer.
    exu_valid = 1'b0;
    lsu_data  = 32'h2FF;
    push(5'd2, 32'h2FF);
    #1;
    chk("solo_lsu_ready", 64'(lsu_ready), 64'h1);
    chk("solo_exu_ready", 64'(exu_ready), 64'h0);
    tick();
    exu_valid = 1'b1; exu_data = 32'h1FF;
    lsu_data  = 32'h2FE;
    push(5'd2, 32'h2FE);
    #1;
    chk("tie_after_solo_lsu", 64'(lsu_ready), 64'h1);
    chk("tie_after_solo_exu", 64'(exu_ready), 64'h0);
    tick();
    exu_valid = 1'b0;
    lsu_valid = 1'b0;
    tick();
    tick();

    // Writeback to a non-busy register flags a sticky error.
    do_reset();
    chk("err_clear", 64'(wb_err), 64'h0);
    lsu_valid = 1'b1; lsu_addr = 5'd9; lsu_data = 32'h9999_0009;
    push(5'd9, 32'h9999_0009);
    #1 chk("err_lsu_ready", 64'(lsu_ready), 64'h1);
    tick();
    lsu_valid = 1'b0;
    #1;
    chk("err_rf_we", 64'(rf_we), 64'h1);
    chk("err_rf_waddr", 64'(rf_waddr), 64'h9);
    chk("err_set", 64'(wb_err), 64'h1);
    repeat (3) tick();
    chk("err_sticky", 64'(wb_err), 64'h1);
    rst = 1'b0;
    #1 chk("err_reset", 64'(wb_err), 64'h0);
    tick();
    rst = 1'b1;
    tick();

    chk("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
    $finish;
  end

endmodule
